// File: rtl/systick_pkg.sv
// rtl/systick_pkg.sv - shared constants for the systick timer slice
package systick_pkg;

    localparam int CNT_W_DEFAULT = 24;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_LOAD  = 2'd1;
    localparam logic [1:0] ADDR_VAL   = 2'd2;
    localparam logic [1:0] ADDR_CALIB = 2'd3;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_TICKINT   = 1;
    localparam int CTRL_CLKSOURCE = 2;
    localparam int CTRL_COUNTFLAG = 16;

endpackage

// File: rtl/systick_ref_edge.sv
// rtl/systick_ref_edge.sv - reference clock rising-edge detector, optional synchronizer (SYSTICK_REF_SYNC_EN)
module systick_ref_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ref,
    output logic o_tick
);

    logic w_ref;
    logic r_prev;
    logic r_tick;

`ifdef SYSTICK_REF_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_ref};
        end
    end

    assign w_ref = r_sync[1];
`else
    assign w_ref = i_ref;
`endif

    // Edge history runs regardless of clock source so a source switch never sees stale history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_prev <= w_ref;
            r_tick <= w_ref & ~r_prev;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/systick_timer.sv
// rtl/systick_timer.sv - 24-bit down-counting system tick timer with word-register bus
module systick_timer
    import systick_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEFAULT,
    parameter logic [23:0] CALIB_TENMS = 24'd0,
    parameter logic        CALIB_NOREF = 1'b0,
    parameter logic        CALIB_SKEW  = 1'b1
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        ref_clk,
    input  logic        bus_sel,
    input  logic        bus_wr,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        systick_irq
);

    logic             r_enable;
    logic             r_tickint;
    logic             r_clksource;
    logic             r_countflag;
    logic [CNT_W-1:0] r_load;
    logic [CNT_W-1:0] r_val;
    logic [31:0]      r_rdata;
    logic             r_irq;

    logic        w_ref_tick;
    logic        w_tick;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_val;
    logic        w_rd_ctrl;
    logic [31:0] w_ctrl;
    logic [31:0] w_rdata;
    logic        w_unused;

    systick_ref_edge u_ref_edge (
        .clk    (CLK),
        .rst_n  (reset_n),
        .i_ref  (ref_clk),
        .o_tick (w_ref_tick)
    );

    assign w_tick    = r_clksource ? 1'b1 : w_ref_tick;
    assign w_rd      = bus_sel & ~bus_wr;
    assign w_wr_ctrl = bus_sel & bus_wr & (bus_addr == ADDR_CTRL);
    assign w_wr_load = bus_sel & bus_wr & (bus_addr == ADDR_LOAD);
    assign w_wr_val  = bus_sel & bus_wr & (bus_addr == ADDR_VAL);
    assign w_rd_ctrl = w_rd & (bus_addr == ADDR_CTRL);
    assign w_unused  = ^bus_wdata;

    always_comb begin
        w_ctrl                 = 32'd0;
        w_ctrl[CTRL_ENABLE]    = r_enable;
        w_ctrl[CTRL_TICKINT]   = r_tickint;
        w_ctrl[CTRL_CLKSOURCE] = r_clksource;
        w_ctrl[CTRL_COUNTFLAG] = r_countflag;
    end

    always_comb begin
        w_rdata = 32'd0;
        case (bus_addr)
            ADDR_CTRL:  w_rdata = w_ctrl;
            ADDR_LOAD:  w_rdata = 32'(r_load);
            ADDR_VAL:   w_rdata = 32'(r_val);
            ADDR_CALIB: w_rdata = {CALIB_NOREF, CALIB_SKEW, 6'b0, CALIB_TENMS};
            default:    w_rdata = 32'd0;
        endcase
    end

    // Later assignments win: flag set beats CTRL-read clear, VAL write beats the tick
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_enable    <= 1'b0;
            r_tickint   <= 1'b0;
            r_clksource <= 1'b0;
            r_countflag <= 1'b0;
            r_load      <= '0;
            r_val       <= '0;
            r_rdata     <= 32'd0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_wr_ctrl) begin
                r_enable    <= bus_wdata[CTRL_ENABLE];
                r_tickint   <= bus_wdata[CTRL_TICKINT];
                r_clksource <= bus_wdata[CTRL_CLKSOURCE];
            end
            if (w_wr_load) begin
                r_load <= bus_wdata[CNT_W-1:0];
            end
            if (w_rd_ctrl) begin
                r_countflag <= 1'b0;
            end
            if (w_wr_val) begin
                r_val       <= '0;
                r_countflag <= 1'b0;
            end else if (r_enable && w_tick) begin
                if (r_val == '0) begin
                    r_val <= r_load;
                end else if (r_val == CNT_W'(1)) begin
                    r_val       <= '0;
                    r_countflag <= 1'b1;
                    r_irq       <= r_tickint;
                end else begin
                    r_val <= r_val - CNT_W'(1);
                end
            end
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign bus_rdata   = r_rdata;
    assign systick_irq = r_irq;

endmodule

// File: tb/tb_systick_timer.sv
// tb/tb_systick_timer.sv - directed self-checking bench for systick_timer
module tb_systick_timer;

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_LOAD  = 2'd1;
    localparam logic [1:0] A_VAL   = 2'd2;
    localparam logic [1:0] A_CALIB = 2'd3;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        ref_clk = 1'b0;
    logic        bus_sel = 1'b0;
    logic        bus_wr = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic [31:0] bus_rdata;
    logic        systick_irq;
    logic [2:0]  div_cnt = 3'd0;

    int n_checks = 0;
    int n_errors = 0;

    systick_timer dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .ref_clk     (ref_clk),
        .bus_sel     (bus_sel),
        .bus_wr      (bus_wr),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .systick_irq (systick_irq)
    );

    always #5 CLK = ~CLK;

    // Divide-by-8 fclk, launched just after the CLK edge like a synchronous divider output
    always @(posedge CLK) begin
        #1;
        div_cnt = div_cnt + 3'd1;
        ref_clk = div_cnt[2];
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge CLK); #1;
        bus_sel = 1'b0; bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge CLK); #1;
        bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = a;
        @(posedge CLK); #1;
        bus_sel = 1'b0;
        d = bus_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (bus_rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rdata: got %h expected %h", bus_rdata, 32'd0); end
        n_checks++;
        if (systick_irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b expected 0", systick_irq); end
        reset_n = 1'b1;
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'd0); end
        bus_read(A_LOAD, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL reset_load: got %h expected %h", d, 32'd0); end
        bus_read(A_VAL, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL reset_val: got %h expected %h", d, 32'd0); end
        bus_read(A_CALIB, d);
        n_checks++;
        if (d !== 32'h4000_0000) begin n_errors++; $display("FAIL reset_calib: got %h expected %h", d, 32'h4000_0000); end
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (bus_rdata !== 32'h4000_0000) begin n_errors++; $display("FAIL rdata_hold: got %h expected %h", bus_rdata, 32'h4000_0000); end
    endtask

    task automatic test_clk_source();
        logic [31:0] d;
        logic [31:0] exp_rd [0:10] = '{32'd0, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0,
                                       32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        bus_write(A_LOAD, 32'd4);
        bus_write(A_VAL, 32'd0);
        bus_write(A_CTRL, 32'd7);
        bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = A_VAL;
        for (int k = 1; k <= 11; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            n_checks++;
            if (bus_rdata !== exp_rd[k-1]) begin n_errors++; $display("FAIL clk_val_seq[%0d]: got %h expected %h", k, bus_rdata, exp_rd[k-1]); end
            n_checks++;
            if (systick_irq !== (k == 5 || k == 10)) begin n_errors++; $display("FAIL clk_irq[%0d]: got %b expected %b", k, systick_irq, (k == 5 || k == 10)); end
        end
        bus_sel = 1'b0;
        bus_write(A_CTRL, 32'd6);
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 32'h0001_0006) begin n_errors++; $display("FAIL clk_countflag_set: got %h expected %h", d, 32'h0001_0006); end
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 32'h0000_0006) begin n_errors++; $display("FAIL clk_countflag_clr: got %h expected %h", d, 32'h0000_0006); end
    endtask

    task automatic test_ref_source();
        int n;
        bit found;
        bus_write(A_CTRL, 32'd0);
        bus_write(A_LOAD, 32'd2);
        bus_write(A_VAL, 32'd0);
        bus_write(A_CTRL, 32'd3);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (systick_irq) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL ref_first_irq: got none expected pulse within 200 cycles"); end
        for (int p = 0; p < 2; p++) begin
            n = 0;
            found = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge CLK);
                n++;
                if (systick_irq) begin found = 1'b1; break; end
            end
            n_checks++;
            if (!found || n != 24) begin n_errors++; $display("FAIL ref_irq_period[%0d]: got %0d expected 24", p, found ? n : -1); end
        end
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        bus_write(A_CTRL, 32'd0);
        bus_write(A_LOAD, 32'd4);
        bus_write(A_VAL, 32'd0);
        bus_write(A_CTRL, 32'd7);
        repeat (3) @(posedge CLK);
        bus_write(A_VAL, 32'hDEAD_BEEF);
        n_checks++;
        if (systick_irq !== 1'b0) begin n_errors++; $display("FAIL col_val_wr_irq: got %b expected 0", systick_irq); end
        bus_write(A_CTRL, 32'd6);
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 32'h0000_0006) begin n_errors++; $display("FAIL col_val_wr_flag: got %h expected %h", d, 32'h0000_0006); end
        bus_read(A_VAL, d);
        n_checks++;
        if (d !== 32'd3) begin n_errors++; $display("FAIL col_val_after: got %h expected %h", d, 32'd3); end
        bus_write(A_CTRL, 32'd7);
        @(posedge CLK);
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 32'h0000_0007) begin n_errors++; $display("FAIL col_rd_flag_pre: got %h expected %h", d, 32'h0000_0007); end
        n_checks++;
        if (systick_irq !== 1'b1) begin n_errors++; $display("FAIL col_rd_irq: got %b expected 1", systick_irq); end
        bus_write(A_CTRL, 32'd6);
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 32'h0001_0006) begin n_errors++; $display("FAIL col_rd_flag_kept: got %h expected %h", d, 32'h0001_0006); end
    endtask

    task automatic test_edges();
        logic [31:0] d;
        int irq_cnt;
        bus_write(A_LOAD, 32'd0);
        bus_write(A_VAL, 32'd0);
        bus_write(A_CTRL, 32'd7);
        irq_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (systick_irq) irq_cnt++;
        end
        n_checks++;
        if (irq_cnt != 0) begin n_errors++; $display("FAIL load0_irq: got %0d pulses expected 0", irq_cnt); end
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 32'h0000_0007) begin n_errors++; $display("FAIL load0_flag: got %h expected %h", d, 32'h0000_0007); end
        bus_write(A_LOAD, 32'hFFFF_FFFF);
        bus_read(A_VAL, d);
        n_checks++;
        if (d !== 32'h00FF_FFFF) begin n_errors++; $display("FAIL max_reload: got %h expected %h", d, 32'h00FF_FFFF); end
        bus_read(A_LOAD, d);
        n_checks++;
        if (d !== 32'h00FF_FFFF) begin n_errors++; $display("FAIL max_load: got %h expected %h", d, 32'h00FF_FFFF); end
        bus_write(A_CALIB, 32'hFFFF_FFFF);
        bus_read(A_CALIB, d);
        n_checks++;
        if (d !== 32'h4000_0000) begin n_errors++; $display("FAIL calib_ro: got %h expected %h", d, 32'h4000_0000); end
        bus_write(A_CTRL, 32'hFFFE_0003);
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 32'h0000_0003) begin n_errors++; $display("FAIL ctrl_hi_ignored: got %h expected %h", d, 32'h0000_0003); end
    endtask

    task automatic test_disruptions();
        logic [31:0] d;
        bus_write(A_CTRL, 32'd0);
        bus_write(A_LOAD, 32'd4);
        bus_write(A_VAL, 32'd0);
        bus_write(A_CTRL, 32'd7);
        bus_write(A_CTRL, 32'd0);
        repeat (20) @(posedge CLK);
        bus_read(A_VAL, d);
        n_checks++;
        if (d !== 32'd3) begin n_errors++; $display("FAIL disable_hold: got %h expected %h", d, 32'd3); end
        bus_write(A_CTRL, 32'd7);
        bus_read(A_VAL, d);
        n_checks++;
        if (d !== 32'd2) begin n_errors++; $display("FAIL reenable_resume: got %h expected %h", d, 32'd2); end
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (systick_irq !== 1'b1) begin n_errors++; $display("FAIL pre_reset_irq: got %b expected 1", systick_irq); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (systick_irq !== 1'b0) begin n_errors++; $display("FAIL async_reset_irq: got %b expected 0", systick_irq); end
        n_checks++;
        if (bus_rdata !== 32'd0) begin n_errors++; $display("FAIL async_reset_rdata: got %h expected %h", bus_rdata, 32'd0); end
        #2;
        reset_n = 1'b1;
        bus_read(A_CTRL, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL post_reset_ctrl: got %h expected %h", d, 32'd0); end
        bus_read(A_LOAD, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL post_reset_load: got %h expected %h", d, 32'd0); end
        bus_read(A_VAL, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL post_reset_val: got %h expected %h", d, 32'd0); end
    endtask

    initial begin
        test_reset();
        test_clk_source();
        test_ref_source();
        test_collisions();
        test_edges();
        test_disruptions();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
